// File: rtl/dot_prod_peak.sv
// Frame-based peak search over i^2+q^2 of a product stream.
// Three-stage pipeline (square, sum, compare) feeding a handshaked peak result.
module dot_prod_peak #(
    parameter int i_bits       = 24,
    parameter int q_bits       = 24,
    parameter int frame_length = 16,
    parameter int index_bits   = 4,
    parameter int mag_bits     = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m_axis_product_tvalid,
    input  logic signed [i_bits-1:0]    i,
    input  logic signed [q_bits-1:0]    q,
    output logic                        s_axis_product_tready,
    input  logic                        m_axis_peak_tready,
    output logic                        s_axis_peak_tvalid,
    output logic [mag_bits-1:0]         peak_mag,
    output logic [index_bits-1:0]       peak_index
);

    localparam logic [index_bits-1:0] LastIdx = index_bits'(frame_length - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [index_bits-1:0]   r_idx;

    logic                    r_s1_valid;
    logic [mag_bits-1:0]     r_s1_isq;
    logic [mag_bits-1:0]     r_s1_qsq;
    logic [index_bits-1:0]   r_s1_idx;

    logic                    r_s2_valid;
    logic [mag_bits-1:0]     r_s2_mag;
    logic [index_bits-1:0]   r_s2_idx;

    logic [mag_bits-1:0]     r_best_mag;
    logic [index_bits-1:0]   r_best_idx;

    logic                    w_accept;
    logic                    w_peak_hs;
    logic                    w_s2_last;
    logic                    w_take;
    logic [mag_bits-1:0]     w_cand_mag;
    logic [index_bits-1:0]   w_cand_idx;
    logic signed [mag_bits-1:0] w_i_ext;
    logic signed [mag_bits-1:0] w_q_ext;
    logic [mag_bits-1:0]     w_i_sq;
    logic [mag_bits-1:0]     w_q_sq;

    // Squaring at full output width keeps the result exact for the most negative input.
    assign w_i_ext = {{(mag_bits - i_bits){i[i_bits-1]}}, i};
    assign w_q_ext = {{(mag_bits - q_bits){q[q_bits-1]}}, q};
    assign w_i_sq  = $unsigned(w_i_ext * w_i_ext);
    assign w_q_sq  = $unsigned(w_q_ext * w_q_ext);

    assign w_accept   = m_axis_product_tvalid && s_axis_product_tready;
    assign w_peak_hs  = s_axis_peak_tvalid && m_axis_peak_tready;
    assign w_s2_last  = r_s2_valid && (r_s2_idx == LastIdx);
    assign w_take     = r_s2_valid && ((r_s2_idx == '0) || (r_s2_mag > r_best_mag));
    assign w_cand_mag = w_take ? r_s2_mag : r_best_mag;
    assign w_cand_idx = w_take ? r_s2_idx : r_best_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        s_axis_product_tready = 1'b0;
        case (r_state)
            ACCUM: begin
                s_axis_product_tready = !rst;
                if (w_accept && (r_idx == LastIdx)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_s2_last) begin
                    w_state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (w_peak_hs) begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_isq   <= '0;
            r_s1_qsq   <= '0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_idx   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_isq <= w_i_sq;
                r_s1_qsq <= w_q_sq;
                r_s1_idx <= r_idx;
                r_idx    <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mag <= r_s1_isq + r_s1_qsq;
                r_s2_idx <= r_s1_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_mag         <= '0;
            r_best_idx         <= '0;
            s_axis_peak_tvalid <= 1'b0;
            peak_mag           <= '0;
            peak_index         <= '0;
        end else begin
            if (w_peak_hs) begin
                r_best_mag <= '0;
                r_best_idx <= '0;
            end else if (w_take) begin
                r_best_mag <= r_s2_mag;
                r_best_idx <= r_s2_idx;
            end
            // The last sample's compare result goes straight to the output on the same edge.
            if (w_s2_last) begin
                peak_mag           <= w_cand_mag;
                peak_index         <= w_cand_idx;
                s_axis_peak_tvalid <= 1'b1;
            end else if (w_peak_hs) begin
                s_axis_peak_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dot_prod_peak.sv
// Scoreboard bench for dot_prod_peak with 8-bit products and 4-sample frames.
module tb_dot_prod_peak;

    logic              clk = 1'b0;
    logic              rst;
    logic              pvalid;
    logic signed [7:0] i_r;
    logic signed [7:0] q_r;
    logic              ptready_out;
    logic              kready;
    logic              kvalid;
    logic [15:0]       peak_mag;
    logic [1:0]        peak_index;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_cyc = 0;
    int n_results = 0;
    longint last_mag;
    longint last_idx;

    longint sb_mag[$];
    longint sb_idx[$];

    int m_cnt  = 0;
    int m_best = 0;
    int m_bidx = 0;

    dot_prod_peak #(
        .i_bits      (8),
        .q_bits      (8),
        .frame_length(4),
        .index_bits  (2),
        .mag_bits    (16)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .m_axis_product_tvalid(pvalid),
        .i                    (i_r),
        .q                    (q_r),
        .s_axis_product_tready(ptready_out),
        .m_axis_peak_tready   (kready),
        .s_axis_peak_tvalid   (kvalid),
        .peak_mag             (peak_mag),
        .peak_index           (peak_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model and output monitor, both sampled mid-cycle.
    always @(negedge clk) begin
        int a;
        int b;
        int mag;
        cyc++;
        if (exp_cyc != 0 && cyc == exp_cyc - 1) check("lat_early", kvalid, 0);
        if (exp_cyc != 0 && cyc == exp_cyc) begin
            check("lat_valid", kvalid, 1);
            exp_cyc = 0;
        end
        if (rst) begin
            m_cnt   = 0;
            exp_cyc = 0;
        end else begin
            if (kvalid && kready) begin
                if (sb_mag.size() == 0) begin
                    check("sb_unexpected", 1, 0);
                end else begin
                    check("peak_mag", peak_mag, sb_mag.pop_front());
                    check("peak_idx", peak_index, sb_idx.pop_front());
                end
                last_mag = peak_mag;
                last_idx = peak_index;
                n_results++;
            end
            if (pvalid && ptready_out) begin
                a   = i_r;
                b   = q_r;
                mag = a * a + b * b;
                if (m_cnt == 0 || mag > m_best) begin
                    m_best = mag;
                    m_bidx = m_cnt;
                end
                m_cnt++;
                if (m_cnt == 4) begin
                    sb_mag.push_back(m_best);
                    sb_idx.push_back(m_bidx);
                    m_cnt   = 0;
                    exp_cyc = cyc + 3;
                end
            end
        end
    end

    task automatic send(input int a, input int b);
        bit got;
        bit done;
        done   = 0;
        i_r    = 8'(a);
        q_r    = 8'(b);
        pvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            got = ptready_out;
            @(posedge clk);
            #1;
            if (got) done = 1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        pvalid = 1'b0;
        i_r    = '0;
        q_r    = '0;
    endtask

    task automatic wait_results(input int target);
        for (int n = 0; n < 100 && n_results < target; n++) @(negedge clk);
        check("result_wait", n_results >= target, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_zero_check(input string tag);
        check({tag, "_ptready"}, ptready_out, 0);
        check({tag, "_kvalid"}, kvalid, 0);
        check({tag, "_mag"}, peak_mag, 0);
        check({tag, "_idx"}, peak_index, 0);
    endtask

    initial begin
        int base;
        rst    = 1'b1;
        kready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_zero_check("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(3, 4); send(1, 1); send(-6, 0); send(2, 2); idle();
        wait_results(1);
        check("f1_mag", last_mag, 36);
        check("f1_idx", last_idx, 2);

        send(5, 0); send(0, 5); send(3, 4); send(0, -5); idle();
        wait_results(2);
        check("tie_mag", last_mag, 25);
        check("tie_idx", last_idx, 0);

        send(0, 0); send(0, 0); send(0, 0); send(-128, -128); idle();
        wait_results(3);
        check("max_mag", last_mag, 32768);
        check("max_idx", last_idx, 3);

        // Back-pressure: result must hold while stray input valids are ignored.
        kready = 1'b0;
        send(1, 2); send(7, 0); send(0, 0); send(3, 3);
        i_r = 8'sd100;
        q_r = 8'sd100;
        for (int n = 0; n < 20 && !kvalid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("hold_kvalid", kvalid, 1);
            check("hold_mag", peak_mag, 49);
            check("hold_idx", peak_index, 1);
            check("hold_ptready", ptready_out, 0);
        end
        @(posedge clk);
        #1;
        kready = 1'b1;
        idle();
        wait_results(4);
        check("hold_res_mag", last_mag, 49);

        // Mid-frame reset discards the partial frame.
        send(100, 100); send(90, 90); idle();
        rst = 1'b1;
        @(negedge clk);
        reset_zero_check("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 1); send(2, 0); send(0, -3); send(1, 1); idle();
        wait_results(5);
        check("rst_frame_mag", last_mag, 9);
        check("rst_frame_idx", last_idx, 2);

        // Continuous stream over three frames.
        base = n_results;
        for (int n = 0; n < 12; n++) begin
            send($signed(8'($urandom)), $signed(8'($urandom)));
        end
        idle();
        wait_results(base + 3);
        repeat (4) @(negedge clk);
        check("stream_results", n_results - base, 3);
        check("sb_drained", sb_mag.size(), 0);
        check("model_frame_pos", m_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_prod_peak.md
DOT_PROD_PEAK -- requirements
Module: dot_prod_peak

Interface
REQ-001 SHALL have parameter i_bits, default 24, signed width of the input I product.
REQ-002 SHALL have parameter q_bits, default 24, signed width of the input Q product; i_bits == q_bits is required.
REQ-003 SHALL have parameter frame_length, default 16, number of products per search frame (>= 1).
REQ-004 SHALL have parameter index_bits, default 4, width of the index counter; 2^index_bits >= frame_length.
REQ-005 SHALL have parameter mag_bits, default 48, equal to 2*i_bits.
REQ-006 SHALL have port clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port m_axis_product_tvalid  in  1  input product valid, driven by the upstream dot_prod_pip s_axis_product_tvalid.
REQ-009 SHALL have port i  in  i_bits  signed input I product.
REQ-010 SHALL have port q  in  q_bits  signed input Q product.
REQ-011 SHALL have port s_axis_product_tready  out  1  ready to accept a product.
REQ-012 SHALL have port m_axis_peak_tready  in  1  downstream ready for the peak result.
REQ-013 SHALL have port s_axis_peak_tvalid  out  1  peak result valid.
REQ-014 SHALL have port peak_mag  out  mag_bits  unsigned i^2+q^2 of the frame peak.
REQ-015 SHALL have port peak_index  out  index_bits  position of the peak within the frame (0-based).

Function
REQ-016 SHALL accept a product at a rising edge only when m_axis_product_tvalid and s_axis_product_tready are both 1; i and q are otherwise ignored.
REQ-017 SHALL register the exact unsigned squares i*i and q*q, plus the sample index, at the acceptance edge (stage 1).
REQ-018 SHALL register mag = i*i + q*q at the next edge (stage 2), with no truncation or overflow at mag_bits.
REQ-019 SHALL, at the following edge (stage 3), replace the running best when mag > best_mag strictly; on ties the lower index is retained.
REQ-020 SHALL load best unconditionally from stage 3 for index 0 of each frame.
REQ-021 SHALL use a state machine with states ACCUM, DRAIN and OUTPUT.
REQ-022 SHALL drive s_axis_product_tready = 1 only in ACCUM with rst low.
REQ-023 SHALL increment the index counter on each acceptance, wrapping from frame_length-1 to 0.
REQ-024 SHALL move ACCUM -> DRAIN on acceptance of index frame_length-1.
REQ-025 SHALL move DRAIN -> OUTPUT once the last sample has passed stage 3.
REQ-026 SHALL, if the last product is accepted at edge k, load peak_mag and peak_index and set s_axis_peak_tvalid = 1 at edge k+2 (fixed latency).
REQ-027 SHALL hold peak_mag, peak_index and s_axis_peak_tvalid stable in OUTPUT while m_axis_peak_tready = 0.
REQ-028 SHALL, on the edge where s_axis_peak_tvalid and m_axis_peak_tready are both 1, clear s_axis_peak_tvalid, clear best, and return to ACCUM; a new product is accepted no earlier than the next edge.
REQ-029 SHALL, when frame_length = 1, output every accepted product with index 0.

Reset
REQ-030 SHALL, while rst is high, force state ACCUM, index counter 0, pipeline valids 0, best 0, s_axis_peak_tvalid 0, peak_mag 0, peak_index 0 and s_axis_product_tready 0.
REQ-031 SHALL, when rst asserts mid-frame, discard the partial frame; the first product accepted after rst deasserts is index 0.

Verification (i_bits=8, frame_length=4, index_bits=2)
REQ-032 SHALL cover: (3,4),(1,1),(-6,0),(2,2) -> peak_mag 36, peak_index 2, tvalid 2 edges after the 4th acceptance.
REQ-033 SHALL cover: (5,0),(0,5),(3,4),(0,-5) -> peak_mag 25, peak_index 0 (tie rule).
REQ-034 SHALL cover: (-128,-128) at index 3, others (0,0) -> peak_mag 32768, peak_index 3.
REQ-035 SHALL cover: m_axis_peak_tready held 0 for 5 cycles after tvalid -> outputs stable, s_axis_product_tready 0, input valids ignored; the frame is consumed on the ready edge.
REQ-036 SHALL cover: rst pulsed after 2 acceptances -> all outputs 0; the next 4 products form a complete frame with correct peak and index.
REQ-037 SHALL cover: continuous m_axis_product_tvalid over 3 frames with m_axis_peak_tready = 1 -> 3 results, each with correct peak and index, and no products lost or double-counted.
